uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter: 8 data bits, LSB first, 1 start bit (0), 1 stop bit (1), optional parity.
//   Counterpart of the team's UART receiver; shares its baud convention (CLKS_PER_BIT = f_clk / f_baud).
//   Sits between the RSA pipeline's result/debug path and the FPGA TX pin.
//   Accepts one byte per valid/ready handshake; supports back-to-back frames without an idle gap.
// PARAMETERS
//   CLKS_PER_BIT  87  clock cycles per serial bit; legal range 2..65535 (e.g. 10 MHz / 115200 = 87)
//   PARITY_ODD    0   parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
//   i_Clock      in   1  single clock; all logic is on its rising edge
//   i_Reset      in   1  asynchronous, active-high reset
//   i_Tx_DV      in   1  byte valid; a transfer occurs on an edge where i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte    in   8  byte to send; sampled only on the transfer edge
//   o_Tx_Ready   out  1  high only in state IDLE
//   o_Tx_Active  out  1  high from the start bit through the last stop-bit cycle
//   o_Tx_Serial  out  1  serial line, registered, idle high
//   o_Tx_Done    out  1  one-cycle pulse after the stop bit completes
// BEHAVIOUR
//   Reset (async): state=IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, counters=0, shift reg=0.
//     o_Tx_Ready=1 while in IDLE, including immediately after reset release.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: o_Tx_Serial=1. On a transfer edge: latch i_Tx_Byte, clear bit counter and bit index,
//     and go to START. The cycle after the transfer: o_Tx_Serial=0, o_Tx_Active=1, o_Tx_Ready=0.
//   Every bit holds exactly CLKS_PER_BIT cycles.
//     The clock counter runs 0..CLKS_PER_BIT-1; it advances state/bit at CLKS_PER_BIT-1 and wraps to 0.
//   DATA: o_Tx_Serial = byte[bit_idx], bit_idx 0..7. After bit 7 go to PARITY if enabled, else STOP.
//   STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles. On its last cycle: go to IDLE, set o_Tx_Done=1,
//     clear o_Tx_Active. o_Tx_Done lasts one cycle.
//   Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
//   Back-to-back: o_Tx_Ready is high in the same cycle as o_Tx_Done. A transfer on that edge
//     starts the next start bit on the following cycle, giving zero idle bits between frames.
//   i_Tx_DV while o_Tx_Ready=0 is ignored; no buffering, no error flag.
//     Changes to i_Tx_Byte mid-frame have no effect.
//   Reset mid-frame: the frame is aborted, the line returns to 1 asynchronously, and no o_Tx_Done is issued.
//   Clock counter width: $clog2(CLKS_PER_BIT); comparisons are done at that width, with no truncation.
//   Illegal state encodings go to IDLE with o_Tx_Serial=1.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: a PARITY state is inserted after DATA.
//     Parity bit = ^byte (even) or ~^byte (odd, per PARITY_ODD), held CLKS_PER_BIT cycles.
//   UART_TX_PARITY_EN undefined: no PARITY state, PARITY_ODD is unused,
//     and the frame is exactly 10 bits, wire-compatible with the UART receiver.
// STRUCTURE
//   uart_pkg: tx state enum (IDLE/START/DATA/PARITY/STOP), UART_DATA_BITS=8, idle line level
//     constant; also shared by the receiver.
//   One sub-module: uart_baud_tick (counter 0..CLKS_PER_BIT-1 with clear input; outputs a
//     bit_end pulse); reusable by the receiver.
//   Shift/select logic and the FSM stay in uart_tx.
// TESTING (CLKS_PER_BIT=4 unless noted)
//   1 Reset release, no DV -> o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0 for 100 cycles.
//   2 Send 0xA5 -> line reads 0, 1,0,1,0,0,1,0,1, 1, each level 4 cycles.
//     o_Tx_Done pulses once, 40 cycles after the transfer edge.
//     The receiver loopback yields 0xA5.
//   3 Back-to-back 0x00 then 0xFF, DV held high -> second start bit immediately follows the first
//     stop bit. Exactly two Done pulses, 80 cycles total.
//   4 DV with 0x3C pulsed mid-frame of 0x55 -> 0x3C never appears on the line; only 0x55 is sent.
//   5 Assert i_Reset during DATA bit 3 -> line=1 within the same cycle, no Done, Ready=1 after
//     release. A following 0x81 is sent correctly.
//   6 UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit=1 and the frame is 44 cycles.
//     With PARITY_ODD=1 the parity bit=0.
//     Also CLKS_PER_BIT=87: send 0x5A and check bit width = 87 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and transmitter state encodings.
// Used by uart_tx and the matching UART receiver.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t TX_IDLE   = 3'd0;
  localparam tx_state_t TX_START  = 3'd1;
  localparam tx_state_t TX_DATA   = 3'd2;
  localparam tx_state_t TX_PARITY = 3'd3;
  localparam tx_state_t TX_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while clr is low, flags the last
// cycle of a bit (bit_end) and the cycle before it (bit_pre_end).
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end     = !clr && (cnt_q == CNT_LAST);
  assign bit_pre_end = !clr && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int                IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535) || (PARITY_ODD < 0) || (PARITY_ODD > 1))
  begin : g_bad_params
    $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
  end

  tx_state_t                 state_q,   state_d;
  logic [UART_DATA_BITS-1:0] data_q,    data_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      serial_q,  serial_d;
  logic                      active_q,  active_d;
  logic                      done_q,    done_d;

  logic bit_end;
  logic bit_pre_end;
  logic baud_clr;

  assign baud_clr = (state_q == TX_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk         (i_Clock),
    .rst         (i_Reset),
    .clr         (baud_clr),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);
`endif

  // STOP hands over to IDLE one cycle early so the IDLE cycle (Ready/Done high)
  // is the final stop-bit cycle; a transfer there gives zero gap between frames.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;

    case (state_q)
      TX_IDLE: begin
        serial_d = UART_IDLE_LEVEL;
        active_d = 1'b0;
        if (i_Tx_DV) begin
          state_d   = TX_START;
          data_d    = i_Tx_Byte;
          bit_idx_d = '0;
          serial_d  = 1'b0;
          active_d  = 1'b1;
        end
      end

      TX_START: begin
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
          serial_d  = data_q[0];
        end
      end

      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d  = TX_PARITY;
            serial_d = parity_bit;
`else
            state_d  = TX_STOP;
            serial_d = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            serial_d  = data_q[bit_idx_d];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_d  = TX_STOP;
          serial_d = UART_IDLE_LEVEL;
        end
      end
`else
      TX_PARITY: begin
        state_d  = TX_IDLE;
        serial_d = UART_IDLE_LEVEL;
        active_d = 1'b0;
      end
`endif

      TX_STOP: begin
        serial_d = UART_IDLE_LEVEL;
        if (bit_pre_end) begin
          state_d = TX_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d  = TX_IDLE;
        serial_d = UART_IDLE_LEVEL;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= TX_IDLE;
      data_q    <= '0;
      bit_idx_q <= '0;
      serial_q  <= UART_IDLE_LEVEL;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Ready  = (state_q == TX_IDLE);
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: captures the serial line cycle by cycle and
// compares it with a frame model built from the byte, bit order and bit period.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS  = PAR_EN ? 11 : 10;
  localparam int N_MAIN = 4;
  localparam int N_WIDE = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv      [3];
  logic [7:0] tx_byte [3];
  logic       serial  [3];
  logic       ready   [3];
  logic       active  [3];
  logic       done    [3];

  int checks = 0;
  int errors = 0;

  logic cap_line[$], cap_done[$], cap_ready[$], cap_active[$];
  logic exp_line[$], exp_done[$], exp_ready[$], exp_active[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N_MAIN), .PARITY_ODD(0)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(tx_byte[0]),
    .o_Tx_Ready(ready[0]), .o_Tx_Active(active[0]), .o_Tx_Serial(serial[0]), .o_Tx_Done(done[0]));

  uart_tx #(.CLKS_PER_BIT(N_MAIN), .PARITY_ODD(1)) u_dut_odd (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(tx_byte[1]),
    .o_Tx_Ready(ready[1]), .o_Tx_Active(active[1]), .o_Tx_Serial(serial[1]), .o_Tx_Done(done[1]));

  uart_tx #(.CLKS_PER_BIT(N_WIDE), .PARITY_ODD(0)) u_dut_wide (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(tx_byte[2]),
    .o_Tx_Ready(ready[2]), .o_Tx_Active(active[2]), .o_Tx_Serial(serial[2]), .o_Tx_Done(done[2]));

  function automatic int n_of(input int sel);
    return (sel == 2) ? N_WIDE : N_MAIN;
  endfunction

  function automatic bit odd_of(input int sel);
    return (sel == 1);
  endfunction

  // Line level of frame slot: start, 8 data bits LSB first, optional parity, stop.
  function automatic logic model_bit(input logic [7:0] b, input bit odd, input int slot);
    int ones;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR_EN && slot == 9) begin
      ones = $countones(b);
      return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    end
    return 1'b1;
  endfunction

  function automatic void clear_all();
    cap_line.delete(); cap_done.delete(); cap_ready.delete(); cap_active.delete();
    exp_line.delete(); exp_done.delete(); exp_ready.delete(); exp_active.delete();
  endfunction

  function automatic void exp_frame(input int sel, input logic [7:0] b);
    int n = n_of(sel);
    int len = NBITS * n;
    for (int s = 0; s < len; s++) begin
      exp_line.push_back(model_bit(b, odd_of(sel), s / n));
      exp_done.push_back(s == len - 1);
      exp_ready.push_back(s == len - 1);
      exp_active.push_back(1'b1);
    end
  endfunction

  function automatic void exp_idle(input int n);
    for (int s = 0; s < n; s++) begin
      exp_line.push_back(1'b1);
      exp_done.push_back(1'b0);
      exp_ready.push_back(1'b1);
      exp_active.push_back(1'b0);
    end
  endfunction

  function automatic int line_diffs();
    int d = 0;
    if (cap_line.size() != exp_line.size()) return -1;
    foreach (exp_line[i]) if (cap_line[i] !== exp_line[i]) d++;
    return d;
  endfunction

  function automatic int flag_diffs();
    int d = 0;
    if (cap_done.size() != exp_done.size()) return -1;
    foreach (exp_done[i]) begin
      if (cap_done[i] !== exp_done[i]) d++;
      if (cap_ready[i] !== exp_ready[i]) d++;
      if (cap_active[i] !== exp_active[i]) d++;
    end
    return d;
  endfunction

  function automatic int count_done();
    int c = 0;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int done_at(input int k);
    int c = 0;
    foreach (cap_done[i]) begin
      if (cap_done[i] === 1'b1) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  // Receiver-style decode: sample each data bit in the middle of its period.
  function automatic logic [7:0] decode(input int base, input int sel);
    int n = n_of(sel);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) begin
      int idx = base + (i + 1) * n + n / 2;
      b[i] = (idx < cap_line.size()) ? cap_line[idx] : 1'bx;
    end
    return b;
  endfunction

  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_line.push_back(serial[sel]);
      cap_done.push_back(done[sel]);
      cap_ready.push_back(ready[sel]);
      cap_active.push_back(active[sel]);
    end
  endtask

  // Called at a negedge with the DUT idle; scrambles i_Tx_Byte after the transfer.
  task automatic send_one(input int sel, input logic [7:0] b, input int extra);
    clear_all();
    dv[sel] = 1'b1;
    tx_byte[sel] = b;
    fork
      capture(sel, NBITS * n_of(sel) + extra);
      begin
        @(negedge clk);
        dv[sel] = 1'b0;
        tx_byte[sel] = 8'($urandom);
      end
    join
    exp_frame(sel, b);
    exp_idle(extra);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({serial[s], ready[s], active[s], done[s]} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %b, expected 1100", s, {serial[s], ready[s], active[s], done[s]});
      end
    end
    rst = 1'b0;
    clear_all();
    capture(0, 100);
    exp_idle(100);
    checks++;
    if (line_diffs() !== 0) begin
      errors++; $display("FAIL reset_idle_line: %0d bad samples, expected 0", line_diffs());
    end
    checks++;
    if (flag_diffs() !== 0) begin
      errors++; $display("FAIL reset_idle_flags: %0d bad samples, expected 0", flag_diffs());
    end
  endtask

  task automatic test_frame_a5();
    int fl = NBITS * N_MAIN;
    send_one(0, 8'hA5, 4);
    checks++;
    if (line_diffs() !== 0) begin
      errors++; $display("FAIL a5_line: %0d bad samples, expected 0", line_diffs());
    end
    checks++;
    if (flag_diffs() !== 0) begin
      errors++; $display("FAIL a5_flags: %0d bad samples, expected 0", flag_diffs());
    end
    checks++;
    if (count_done() !== 1) begin
      errors++; $display("FAIL a5_done_count: got %0d, expected 1", count_done());
    end
    checks++;
    if (done_at(0) !== fl - 1) begin
      errors++; $display("FAIL a5_done_cycle: got %0d, expected %0d", done_at(0) + 1, fl);
    end
    checks++;
    if (decode(0, 0) !== 8'hA5) begin
      errors++; $display("FAIL a5_loopback: got %h, expected a5", decode(0, 0));
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send_one(0, b, $urandom_range(1, 6));
      checks++;
      if (line_diffs() !== 0) begin
        errors++; $display("FAIL rand_line[%h]: %0d bad samples, expected 0", b, line_diffs());
      end
      checks++;
      if (flag_diffs() !== 0) begin
        errors++; $display("FAIL rand_flags[%h]: %0d bad samples, expected 0", b, flag_diffs());
      end
      checks++;
      if (decode(0, 0) !== b) begin
        errors++; $display("FAIL rand_loopback: got %h, expected %h", decode(0, 0), b);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fl = NBITS * N_MAIN;
    clear_all();
    dv[0] = 1'b1;
    tx_byte[0] = 8'h00;
    fork
      capture(0, 2 * fl + 4);
      begin
        @(negedge clk);
        tx_byte[0] = 8'hFF;
        repeat (fl) @(negedge clk);
        dv[0] = 1'b0;
      end
    join
    exp_frame(0, 8'h00);
    exp_frame(0, 8'hFF);
    exp_idle(4);
    checks++;
    if (line_diffs() !== 0) begin
      errors++; $display("FAIL b2b_line: %0d bad samples, expected 0", line_diffs());
    end
    checks++;
    if (flag_diffs() !== 0) begin
      errors++; $display("FAIL b2b_flags: %0d bad samples, expected 0", flag_diffs());
    end
    checks++;
    if (count_done() !== 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d, expected 2", count_done());
    end
    checks++;
    if (done_at(1) !== 2 * fl - 1) begin
      errors++; $display("FAIL b2b_total_cycles: got %0d, expected %0d", done_at(1) + 1, 2 * fl);
    end
    checks++;
    if (decode(fl, 0) !== 8'hFF) begin
      errors++; $display("FAIL b2b_second_byte: got %h, expected ff", decode(fl, 0));
    end
  endtask

  task automatic test_ignore_midframe();
    int fl = NBITS * N_MAIN;
    clear_all();
    dv[0] = 1'b1;
    tx_byte[0] = 8'h55;
    fork
      capture(0, 2 * fl);
      begin
        @(negedge clk);
        dv[0] = 1'b0;
        tx_byte[0] = 8'h00;
        repeat (14) @(negedge clk);
        dv[0] = 1'b1;
        tx_byte[0] = 8'h3C;
        @(negedge clk);
        dv[0] = 1'b0;
      end
    join
    exp_frame(0, 8'h55);
    exp_idle(fl);
    checks++;
    if (line_diffs() !== 0) begin
      errors++; $display("FAIL ignore_line: %0d bad samples, expected 0", line_diffs());
    end
    checks++;
    if (flag_diffs() !== 0) begin
      errors++; $display("FAIL ignore_flags: %0d bad samples, expected 0", flag_diffs());
    end
    checks++;
    if (decode(0, 0) !== 8'h55) begin
      errors++; $display("FAIL ignore_loopback: got %h, expected 55", decode(0, 0));
    end
  endtask

  task automatic test_reset_mid_frame();
    int fl = NBITS * N_MAIN;
    clear_all();
    dv[0] = 1'b1;
    tx_byte[0] = 8'hF0;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (17) @(negedge clk);
    checks++;
    if (serial[0] !== model_bit(8'hF0, 1'b0, 4)) begin
      errors++; $display("FAIL pre_reset_bit3: got %b, expected %b", serial[0], model_bit(8'hF0, 1'b0, 4));
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({serial[0], ready[0], active[0], done[0]} !== 4'b1100) begin
      errors++;
      $display("FAIL async_abort: got %b, expected 1100", {serial[0], ready[0], active[0], done[0]});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    capture(0, 3 * fl);
    exp_idle(3 * fl);
    checks++;
    if (line_diffs() !== 0 || flag_diffs() !== 0) begin
      errors++;
      $display("FAIL post_abort_idle: %0d/%0d bad samples, expected 0/0", line_diffs(), flag_diffs());
    end
    send_one(0, 8'h81, 3);
    checks++;
    if (line_diffs() !== 0 || flag_diffs() !== 0) begin
      errors++;
      $display("FAIL post_abort_frame: %0d/%0d bad samples, expected 0/0", line_diffs(), flag_diffs());
    end
    checks++;
    if (decode(0, 0) !== 8'h81) begin
      errors++; $display("FAIL post_abort_loopback: got %h, expected 81", decode(0, 0));
    end
  endtask

  task automatic test_parity();
    int fl = NBITS * N_MAIN;
    int mid = 9 * N_MAIN + N_MAIN / 2;
    for (int sel = 0; sel < 2; sel++) begin
      send_one(sel, 8'h07, 2);
      checks++;
      if (line_diffs() !== 0 || flag_diffs() !== 0) begin
        errors++;
        $display("FAIL parity_frame[%0d]: %0d/%0d bad samples, expected 0/0", sel, line_diffs(), flag_diffs());
      end
      checks++;
      if (cap_line[mid] !== model_bit(8'h07, odd_of(sel), 9)) begin
        errors++;
        $display("FAIL parity_bit[%0d]: got %b, expected %b", sel, cap_line[mid], model_bit(8'h07, odd_of(sel), 9));
      end
      checks++;
      if (done_at(0) !== fl - 1) begin
        errors++; $display("FAIL parity_frame_len[%0d]: got %0d, expected %0d", sel, done_at(0) + 1, fl);
      end
    end
  endtask

  task automatic test_wide_bit();
    int run0;
    int run1;
    send_one(2, 8'h5A, 4);
    checks++;
    if (line_diffs() !== 0 || flag_diffs() !== 0) begin
      errors++;
      $display("FAIL wide_frame: %0d/%0d bad samples, expected 0/0", line_diffs(), flag_diffs());
    end
    checks++;
    if (decode(0, 2) !== 8'h5A) begin
      errors++; $display("FAIL wide_loopback: got %h, expected 5a", decode(0, 2));
    end
    run0 = 0;
    while (run0 < cap_line.size() && cap_line[run0] === 1'b0) run0++;
    run1 = 0;
    while (run0 + run1 < cap_line.size() && cap_line[run0 + run1] === 1'b1) run1++;
    checks++;
    if (run0 !== 2 * N_WIDE) begin
      errors++; $display("FAIL wide_start_b0_width: got %0d, expected %0d", run0, 2 * N_WIDE);
    end
    checks++;
    if (run1 !== N_WIDE) begin
      errors++; $display("FAIL wide_bit_width: got %0d, expected %0d", run1, N_WIDE);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      dv[s] = 1'b0;
      tx_byte[s] = 8'h00;
    end
    test_reset();
    test_frame_a5();
    test_random();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_mid_frame();
    test_parity();
    test_wide_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
